// File: rtl/mat_softmax_stream.sv
// mat_softmax_stream: row-wise fixed-point softmax over a ROW_IN x COL_IN matrix using one shared datapath.
// Latency: last input of a row to first out_valid is COL_IN + OUT_FRAC+EXP_FRAC+1 + 1 cycles.
// Backpressure: in_ready only in LOAD (rows never overlap); out_ready=0 holds the output register indefinitely.
module mat_softmax_stream #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int FRAC_IN           = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int OUT_FRAC          = 15,
  parameter int EXP_FRAC          = 15,
  parameter int ROW_IN            = 8,
  parameter int COL_IN            = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic                         out_last_col,
  output logic                         out_last_row,
  output logic                         busy
);
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int FT = FRAC_IN + 15;                 // fractional bits of d * log2(e); must be >= EXP_FRAC
  localparam int EW = EXP_FRAC + 1;                 // e is Q1.EXP_FRAC
  localparam int SW = EXP_FRAC + 1 + $clog2(COL_IN);
  localparam int QW = OUT_FRAC + EXP_FRAC + 1;      // dividend 2^(QW-1), one quotient bit per cycle
  localparam int BW = (IW > EW) ? IW : EW;          // buffer holds x first, then e
  localparam int CW = $clog2(COL_IN + 1);
  localparam int AW = $clog2(COL_IN);
  localparam int DW = $clog2(QW);
  localparam int RW = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
  localparam int TW = IW + 18;
  localparam int PW = BW + QW;

  localparam logic [15:0]          LOG2E    = 16'hB8AA;
  localparam logic [CW-1:0]        COL_LAST = CW'(COL_IN - 1);
  localparam logic [CW-1:0]        COL_END  = CW'(COL_IN);
  localparam logic [RW-1:0]        ROW_LAST = RW'(ROW_IN - 1);
  localparam logic [DW-1:0]        DIV_LAST = DW'(QW - 1);
  localparam logic signed [TW-1:0] SH_MAX   = TW'(EXP_FRAC);

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_DIV, S_NORM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [RW-1:0]         row_q, row_d;
  logic signed [IW-1:0]  max_q, max_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [SW-1:0]         rem_q, rem_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic                  ov_q, ov_d, lc_q, lc_d, lr_q, lr_d;
  logic [OW-1:0]         od_q, od_d;
  logic [BW-1:0]         row_buf_q [COL_IN];

  logic                  buf_we;
  logic [BW-1:0]         buf_wd, buf_rd;
  logic signed [IW-1:0]  x_s;
  logic signed [IW:0]    d_s;
  logic signed [TW-1:0]  t_s, sh_s;
  logic [EXP_FRAC-1:0]   frac;
  logic [EW-1:0]         e_val;
  logic [SW:0]           rem_sh;
  logic                  ge;
  logic [PW-1:0]         prod, scaled;
  logic [OW-1:0]         out_sat;

  // Shared datapath: exp of buffered element, divider step, normalised output
  always_comb begin
    buf_rd = row_buf_q[idx_q[AW-1:0]];
    x_s    = $signed(buf_rd[IW-1:0]);
    d_s    = {x_s[IW-1], x_s} - {max_q[IW-1], max_q};
    t_s    = d_s * $signed({1'b0, LOG2E});
    sh_s   = -(t_s >>> FT);                         // -floor(t), never negative since d <= 0
    frac   = t_s[FT-1 -: EXP_FRAC];
    if (sh_s > SH_MAX) e_val = '0;
    else               e_val = {1'b1, frac} >> sh_s;
    rem_sh  = {rem_q, (dcnt_q == '0)};              // dividend has a single 1 at its MSB
    ge      = (rem_sh >= {1'b0, sum_q});
    prod    = PW'(buf_rd) * PW'(quo_q);
    scaled  = prod >> EXP_FRAC;
    out_sat = (|scaled[PW-1:OW]) ? '1 : scaled[OW-1:0];
  end

  // FSM next-state, counters and output register control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    max_d   = max_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dcnt_d  = dcnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    lc_d    = lc_q;
    lr_d    = lr_q;
    buf_we  = 1'b0;
    buf_wd  = BW'(e_val);
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          buf_wd = BW'(in_data);
          if (idx_q == '0 || $signed(in_data) > max_q) max_d = $signed(in_data);
          if (idx_q == COL_LAST) begin
            idx_d   = '0;
            sum_d   = '0;
            state_d = S_EXP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_EXP: begin
        buf_we = 1'b1;
        sum_d  = sum_q + SW'(e_val);
        if (idx_q == COL_LAST) begin
          idx_d   = '0;
          rem_d   = '0;
          quo_d   = '0;
          dcnt_d  = '0;
          state_d = S_DIV;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DIV: begin
        rem_d = ge ? SW'(rem_sh - {1'b0, sum_q}) : SW'(rem_sh);
        quo_d = {quo_q[QW-2:0], ge};
        if (dcnt_q == DIV_LAST) state_d = S_NORM;
        else                    dcnt_d  = dcnt_q + 1'b1;
      end
      S_NORM: begin
        if (ov_q && out_ready && lc_q) begin
          ov_d    = 1'b0;
          lc_d    = 1'b0;
          lr_d    = 1'b0;
          idx_d   = '0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          state_d = S_LOAD;
        end else if ((!ov_q || out_ready) && idx_q != COL_END) begin
          ov_d  = 1'b1;
          od_d  = out_sat;
          lc_d  = (idx_q == COL_LAST);
          lr_d  = (idx_q == COL_LAST) && (row_q == ROW_LAST);
          idx_d = idx_q + 1'b1;
        end else if (ov_q && out_ready) begin
          ov_d = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      row_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      lc_q    <= 1'b0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dcnt_q  <= dcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      lc_q    <= lc_d;
      lr_q    <= lr_d;
    end
  end

  // Row buffer: raw inputs during LOAD, overwritten in place by exp values during EXP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COL_IN; i++) row_buf_q[i] <= '0;
    end else if (buf_we) begin
      row_buf_q[idx_q[AW-1:0]] <= buf_wd;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_last_col = lc_q;
  assign out_last_row = lr_q;
  assign busy         = !(state_q == S_LOAD && idx_q == '0);

endmodule

// File: tb/tb_mat_softmax_stream.sv
// tb_mat_softmax_stream: randomized rows checked against an arithmetic softmax model.
// Latency: n/a (bench).
// Backpressure: out_ready randomly deasserted to exercise output hold.
module tb_mat_softmax_stream;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int LAT = COL + 31 + 1;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        out_last_col, out_last_row, busy;
  logic [15:0] in_data, out_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     acc_cnt  = 0;
  int     row_exp  = 0;
  logic [15:0] row_v [COL];
  longint      exp_o [COL];

  mat_softmax_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last_col (out_last_col),
    .out_last_row (out_last_row),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Count accepted input beats
  always @(posedge clk) if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk_eq(input string tag, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // exp(x - mx) as 2^(floor) * (1 + frac), all in plain integer arithmetic
  function automatic longint exp_fx(longint x, longint mx);
    longint d, t, k, f, unit;
    unit = longint'(1) << 23;
    d = x - mx;
    t = d * 47274;
    k = t / unit;
    if (k * unit > t) k = k - 1;
    f = t - k * unit;
    if (-k > 15) return 0;
    return (32768 + f / 256) >> (-k);
  endfunction

  task automatic model_row();
    longint mx, sum, r, e [COL];
    mx = $signed(row_v[0]);
    for (int i = 1; i < COL; i++) if (longint'($signed(row_v[i])) > mx) mx = $signed(row_v[i]);
    sum = 0;
    for (int i = 0; i < COL; i++) begin
      e[i] = exp_fx(longint'($signed(row_v[i])), mx);
      sum += e[i];
    end
    r = (longint'(1) << 30) / sum;
    for (int i = 0; i < COL; i++) begin
      exp_o[i] = (e[i] * r) >> 15;
      if (exp_o[i] > 65535) exp_o[i] = 65535;
    end
  endtask

  task automatic gen_row(input int mode);
    for (int i = 0; i < COL; i++) begin
      case (mode)
        0:       row_v[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        1:       row_v[i] = 16'($urandom);
        default: row_v[i] = 16'($urandom_range(0, 255)) - 16'd128;
      endcase
    end
  endtask

  // Called at a negedge; returns #1 after the edge accepting the last element
  task automatic send_inputs(input bit hold_vld);
    int tmo;
    for (int i = 0; i < COL; i++) begin
      in_valid = 1'b1;
      in_data  = row_v[i];
      tmo = 0;
      while (!in_ready && tmo < 300) begin
        @(negedge clk);
        tmo++;
      end
      if (!in_ready) chk_eq("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (i < COL - 1) @(negedge clk);
    end
    if (!hold_vld) in_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last output transfer
  task automatic run_row(input bit rnd_rdy, input bit hold_vld);
    int cyc, j, hi_rdy, acc0;
    bit stalled, r;
    logic [15:0] held;
    model_row();
    acc0 = acc_cnt;
    send_inputs(hold_vld);
    cyc = 0;
    hi_rdy = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready) hi_rdy++;
    end
    chk_eq("latency", cyc, LAT);
    chk_eq("in_ready_while_busy", hi_rdy, 0);
    @(negedge clk);
    j = 0;
    stalled = 1'b0;
    held = '0;
    cyc = 0;
    while (j < COL && cyc < 3000) begin
      if (out_valid) begin
        if (stalled) chk_eq("hold_data", out_data, held);
        r = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        out_ready = r;
        if (r) begin
          chk_eq("data", out_data, exp_o[j]);
          chk_eq("last_col", out_last_col, longint'(j == COL - 1));
          chk_eq("last_row", out_last_row, longint'(j == COL - 1 && row_exp == ROW - 1));
          j++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    chk_eq("out_count", j, COL);
    chk_eq("drained_valid", out_valid, 0);
    chk_eq("drained_busy", busy, 0);
    chk_eq("accepts_per_row", acc_cnt - acc0, COL);
    row_exp = (row_exp + 1) % ROW;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_in_ready"}, in_ready, 1);
    chk_eq({tag, "_out_valid"}, out_valid, 0);
    chk_eq({tag, "_out_data"}, out_data, 0);
    chk_eq({tag, "_last_col"}, out_last_col, 0);
    chk_eq({tag, "_last_row"}, out_last_row, 0);
    chk_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #23;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Row 0: eight equal values
    for (int i = 0; i < COL; i++) row_v[i] = 16'h0100;
    run_row(1'b0, 1'b0);
    // Row 1: one max-positive, rest max-negative
    row_v[0] = 16'h7FFF;
    for (int i = 1; i < COL; i++) row_v[i] = 16'h8000;
    run_row(1'b0, 1'b0);
    // Row 2: one 1.0, rest 0
    row_v[0] = 16'h0100;
    for (int i = 1; i < COL; i++) row_v[i] = 16'h0000;
    run_row(1'b1, 1'b0);
    // Rows 3..7 and next matrix rows 0..2, random data and backpressure
    for (int n = 0; n < 8; n++) begin
      gen_row(n % 3);
      run_row(1'b1, 1'b0);
    end

    // Row 3 of second matrix: reset while dividing
    gen_row(0);
    send_inputs(1'b0);
    repeat (20) @(negedge clk);
    chk_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrow_reset");
    @(negedge clk);
    rst_n = 1'b1;
    row_exp = 0;
    @(negedge clk);

    // Full matrix with in_valid held high throughout
    for (int n = 0; n < ROW; n++) begin
      gen_row(n % 3);
      run_row(n[0], 1'b1);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("idle_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
